// File: rtl/mips_state_sequencer.sv
// Multicycle MIPS state sequencer: steps FETCH..WRITE_BACK per instruction, holds on memory
// waitrequest, halts on a fetch from address 0 and keeps retire/stall counters.
module mips_state_sequencer #(
   parameter int unsigned WAIT_TIMEOUT = 0,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       func_code,
   input  logic             pc_zero,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             waitrequest,
   output logic [2:0]       state,
   output logic             stall,
   output logic             active,
   output logic             instr_done,
   output logic             bus_error,
   output logic [CNT_W-1:0] instr_count,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [2:0] S_FETCH  = 3'b000;
   localparam logic [2:0] S_DECODE = 3'b001;
   localparam logic [2:0] S_EXEC   = 3'b010;
   localparam logic [2:0] S_MEM    = 3'b011;
   localparam logic [2:0] S_WB     = 3'b100;
   localparam logic [2:0] S_HALTED = 3'b101;

   localparam int unsigned   WW        = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

   function automatic logic is_load(input logic [5:0] op);
      case (op)
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: is_load = 1'b1;
         default:                                        is_load = 1'b0;
      endcase
   endfunction

   logic [2:0]       state_q, state_d;
   logic             fetch_seen_q, fetch_seen_d;
   logic             pc_zero_q, pc_zero_d;
   logic             active_q, active_d;
   logic             bus_error_q, bus_error_d;
   logic [WW-1:0]    wait_q, wait_d;
   logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic             stall_s, done_s, load_s, halt_req_s, timeout_s;
   logic             unused_s;

   // State register and bookkeeping registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_FETCH;
         fetch_seen_q <= 1'b0;
         pc_zero_q    <= 1'b0;
         active_q     <= 1'b1;
         bus_error_q  <= 1'b0;
         wait_q       <= '0;
         instr_cnt_q  <= '0;
         stall_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         fetch_seen_q <= fetch_seen_d;
         pc_zero_q    <= pc_zero_d;
         active_q     <= active_d;
         bus_error_q  <= bus_error_d;
         wait_q       <= wait_d;
         instr_cnt_q  <= instr_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   // Next-state logic; a timeout overrides the hold and forces HALTED
   always_comb begin
      state_d = state_q;
      if (timeout_s) begin
         state_d = S_HALTED;
      end else if (stall_s) begin
         state_d = state_q;
      end else begin
         case (state_q)
            S_FETCH:  state_d = halt_req_s ? S_HALTED : S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_MEM;
            S_MEM:    state_d = load_s ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_FETCH;
         endcase
      end
   end

   // Output decode: stall, retire pulse, halt request and wait timeout
   always_comb begin
      load_s  = is_load(opcode);
      stall_s = (mem_read | mem_write) & waitrequest & ((state_q == S_FETCH) | (state_q == S_MEM));
      if (state_q == S_MEM) begin
         done_s = ~stall_s & ~load_s;
      end else if (state_q == S_WB) begin
         done_s = 1'b1;
      end else begin
         done_s = 1'b0;
      end
      // pc_zero only counts as seen on the first cycle of a fetch, even if that fetch stalls
      halt_req_s = fetch_seen_q ? pc_zero_q : pc_zero;
      timeout_s  = (WAIT_TIMEOUT != 0) && stall_s && (wait_q == WAIT_LAST);
   end

   // Next values of the bookkeeping registers
   always_comb begin
      fetch_seen_d = (state_q == S_FETCH) && (state_d == S_FETCH);
      pc_zero_d    = fetch_seen_q ? pc_zero_q : pc_zero;
      active_d     = (state_d != S_HALTED);
      bus_error_d  = bus_error_q | timeout_s;
      if (!stall_s || (WAIT_TIMEOUT == 0) || timeout_s) begin
         wait_d = '0;
      end else begin
         wait_d = wait_q + WW'(1);
      end
      if (done_s) begin
         instr_cnt_d = instr_cnt_q + CNT_W'(1);
      end else begin
         instr_cnt_d = instr_cnt_q;
      end
      if (stall_s) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // func_code is reserved for future MULT/DIV holds
   assign unused_s    = ^func_code;

   assign state       = state_q;
   assign stall       = stall_s;
   assign active      = active_q;
   assign instr_done  = done_s;
   assign bus_error   = bus_error_q;
   assign instr_count = instr_cnt_q;
   assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_mips_state_sequencer.sv
// Scoreboard bench for mips_state_sequencer: a driver plays the role of decoder and memory,
// queues the expected per-cycle view and per-instruction retire record; monitors compare.
module tb_mips_state_sequencer;

   localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2;
   localparam logic [2:0] MEM = 3'd3, WB = 3'd4, HALTED = 3'd5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  opcode = 6'd0, func_code = 6'd0;
   logic        pc_zero = 1'b0, mem_read = 1'b0, mem_write = 1'b0, waitrequest = 1'b0;

   logic [2:0]  state, state4;
   logic        stall, active, instr_done, bus_error;
   logic        stall4, active4, instr_done4, bus_error4;
   logic [31:0] instr_count, stall_count, instr_count4, stall_count4;

   mips_state_sequencer #(.WAIT_TIMEOUT(0), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .func_code(func_code), .pc_zero(pc_zero),
      .mem_read(mem_read), .mem_write(mem_write), .waitrequest(waitrequest),
      .state(state), .stall(stall), .active(active), .instr_done(instr_done),
      .bus_error(bus_error), .instr_count(instr_count), .stall_count(stall_count));

   mips_state_sequencer #(.WAIT_TIMEOUT(4), .CNT_W(32)) dut4 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .func_code(func_code), .pc_zero(pc_zero),
      .mem_read(mem_read), .mem_write(mem_write), .waitrequest(waitrequest),
      .state(state4), .stall(stall4), .active(active4), .instr_done(instr_done4),
      .bus_error(bus_error4), .instr_count(instr_count4), .stall_count(stall_count4));

   always #5 clk = ~clk;

   typedef struct packed { logic [2:0] st; logic stl; logic dn; } cyc_t;
   typedef struct packed { int lat; int cnt_before; int stalls; } done_t;

   cyc_t  cyc_q[$];
   done_t done_q[$];
   int    checks = 0;
   int    errors = 0;
   int    exp_cnt = 0;
   int    exp_stalls = 0;
   int    lat_cnt = 0;
   cyc_t  mon_c;
   done_t mon_d;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Per-cycle monitor: state/stall/instr_done every cycle, retire record on each instr_done
   always @(negedge clk) begin
      if (!rst_n) begin
         lat_cnt = 0;
      end else begin
         lat_cnt++;
         if (cyc_q.size() > 0) begin
            mon_c = cyc_q.pop_front();
            chk("state", {61'd0, state}, {61'd0, mon_c.st});
            chk("stall", {63'd0, stall}, {63'd0, mon_c.stl});
            chk("instr_done", {63'd0, instr_done}, {63'd0, mon_c.dn});
         end
         if (instr_done === 1'b1) begin
            if (done_q.size() == 0) begin
               chk("unexpected_done", 64'd1, 64'd0);
            end else begin
               mon_d = done_q.pop_front();
               chk("latency", 64'(lat_cnt), 64'(mon_d.lat));
               chk("instr_count_at_done", {32'd0, instr_count}, 64'(mon_d.cnt_before));
               chk("stall_count_at_done", {32'd0, stall_count}, 64'(mon_d.stalls));
            end
            lat_cnt = 0;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic step(input logic [2:0] st, input logic stl, input logic dn);
      cyc_q.push_back('{st: st, stl: stl, dn: dn});
      @(posedge clk);
      #1;
   endtask

   function automatic bit op_is_load(input logic [5:0] op);
      return (op >= 6'h20) && (op <= 6'h26);
   endfunction

   function automatic bit op_is_store(input logic [5:0] op);
      return (op == 6'h28) || (op == 6'h29) || (op == 6'h2a) || (op == 6'h2b) || (op == 6'h2e);
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0; waitrequest = 1'b0; pc_zero = 1'b0;
      opcode = 6'd0; func_code = 6'd0;
      cyc_q.delete();
      done_q.delete();
      exp_cnt = 0;
      exp_stalls = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", {61'd0, state}, {61'd0, FETCH});
      chk("rst_active", {63'd0, active}, 64'd1);
      chk("rst_bus_error", {63'd0, bus_error}, 64'd0);
      chk("rst_instr_done", {63'd0, instr_done}, 64'd0);
      chk("rst_instr_count", {32'd0, instr_count}, 64'd0);
      chk("rst_stall_count", {32'd0, stall_count}, 64'd0);
      chk("rst_dut4_state", {61'd0, state4}, {61'd0, FETCH});
      rst_n = 1'b1;
   endtask

   // One whole instruction: fw fetch wait cycles, mw memory wait cycles
   task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
      bit ld, st;
      int ms;
      ld = op_is_load(op);
      st = op_is_store(op);
      ms = (ld || st) ? mw : 0;
      done_q.push_back('{lat: 4 + fw + ms + (ld ? 1 : 0), cnt_before: exp_cnt,
                         stalls: exp_stalls + fw + ms});
      exp_cnt++;
      exp_stalls += fw + ms;
      pc_zero = 1'b0;
      for (int i = 0; i <= fw; i++) begin
         mem_read = 1'b1; mem_write = 1'b0; waitrequest = (i < fw);
         opcode = 6'($urandom); func_code = 6'($urandom);
         step(FETCH, i < fw, 1'b0);
      end
      mem_read = 1'b0; mem_write = 1'b0; waitrequest = 1'($urandom);
      step(DECODE, 1'b0, 1'b0);
      opcode = op; waitrequest = 1'($urandom);
      step(EXEC, 1'b0, 1'b0);
      for (int i = 0; i <= ms; i++) begin
         mem_read = ld; mem_write = st;
         waitrequest = (i < ms) ? 1'b1 : ((ld || st) ? 1'b0 : 1'($urandom));
         step(MEM, i < ms, (i == ms) && !ld);
      end
      if (ld) begin
         mem_read = 1'b0; mem_write = 1'b0; waitrequest = 1'($urandom);
         step(WB, 1'b0, 1'b1);
      end
   endtask

   logic [5:0] op_tab [15] = '{6'h09, 6'h00, 6'h0f, 6'h3f, 6'h1c, 6'h20, 6'h21, 6'h22,
                               6'h23, 6'h24, 6'h25, 6'h26, 6'h28, 6'h29, 6'h2b};

   initial begin
      do_reset();

      run_instr(6'h09, 0, 0);                  // ADDIU, no waits: 4 cycles
      chk("count_after_addiu", {32'd0, instr_count}, 64'd1);
      run_instr(6'h23, 0, 3);                  // LW with 3 memory waits
      run_instr(6'h09, 2, 0);                  // fetch held by 2 wait cycles

      for (int n = 0; n < 40; n++) begin
         run_instr(op_tab[$urandom_range(0, 14)], $urandom_range(0, 3), $urandom_range(0, 3));
      end
      chk("count_after_random", {32'd0, instr_count}, 64'(exp_cnt));
      chk("stalls_after_random", {32'd0, stall_count}, 64'(exp_stalls));
      chk("dut4_count_after_random", {32'd0, instr_count4}, 64'(exp_cnt));
      chk("dut4_no_bus_error", {63'd0, bus_error4}, 64'd0);

      // JR to 0, then a fetch from address 0 halts
      func_code = 6'h08;
      run_instr(6'h00, 0, 0);
      pc_zero = 1'b1; mem_read = 1'b1; mem_write = 1'b0; waitrequest = 1'b0;
      step(FETCH, 1'b0, 1'b0);
      chk("halt_state", {61'd0, state}, {61'd0, HALTED});
      chk("halt_active", {63'd0, active}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         pc_zero = 1'($urandom); mem_read = 1'b1; waitrequest = 1'b1;
         step(HALTED, 1'b0, 1'b0);
      end
      chk("halt_instr_count", {32'd0, instr_count}, 64'(exp_cnt));
      chk("halt_bus_error", {63'd0, bus_error}, 64'd0);

      // Reset during EXECUTE of SW aborts it without a retire
      do_reset();
      run_instr(6'h09, 1, 0);
      mem_read = 1'b1; mem_write = 1'b0; waitrequest = 1'b0; pc_zero = 1'b0;
      step(FETCH, 1'b0, 1'b0);
      mem_read = 1'b0;
      step(DECODE, 1'b0, 1'b0);
      opcode = 6'h2b;
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_state_async", {61'd0, state}, {61'd0, FETCH});
      chk("abort_instr_count", {32'd0, instr_count}, 64'd0);
      chk("abort_stall_count", {32'd0, stall_count}, 64'd0);
      chk("abort_instr_done", {63'd0, instr_done}, 64'd0);
      cyc_q.delete();
      done_q.delete();
      exp_cnt = 0;
      exp_stalls = 0;
      @(posedge clk);
      #1;
      chk("abort_held_in_fetch", {61'd0, state}, {61'd0, FETCH});
      rst_n = 1'b1;
      run_instr(6'h09, 0, 0);

      // Stuck waitrequest in FETCH: timeout instance halts after 4 stall cycles
      do_reset();
      mem_read = 1'b1; mem_write = 1'b0; waitrequest = 1'b1; pc_zero = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         step(FETCH, 1'b1, 1'b0);
         if (i == 3) begin
            chk("to_state_before", {61'd0, state4}, {61'd0, FETCH});
            chk("to_bus_error_before", {63'd0, bus_error4}, 64'd0);
         end
         if (i == 4) begin
            chk("to_state_halted", {61'd0, state4}, {61'd0, HALTED});
            chk("to_bus_error", {63'd0, bus_error4}, 64'd1);
            chk("to_active", {63'd0, active4}, 64'd0);
         end
      end
      chk("to_stall_count", {32'd0, stall_count4}, 64'd4);
      chk("to_bus_error_sticky", {63'd0, bus_error4}, 64'd1);
      chk("nolimit_stall_count", {32'd0, stall_count}, 64'd6);
      chk("nolimit_bus_error", {63'd0, bus_error}, 64'd0);

      chk("cyc_q_drained", 64'(cyc_q.size()), 64'd0);
      chk("done_q_drained", 64'(done_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
